uart_tx_tick: RTL

- Serial transmitter paced by a one-clk-wide bit-rate enable pulse from the phase-accumulator clock divider. It sits directly downstream of that divider.
- Accepts parallel bytes over a valid/ready handshake and shifts them out LSB first: start bit, data bits, optional parity, stop bit(s).
- Runs entirely in the clk domain; bit_tick is used only as an enable, never as a clock.

---
 rtl/uart_tx_tick.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_tick.sv
//------------------------------------------------------------------------------
// uart_tx_tick : byte-wide UART transmitter paced by an external bit-rate tick
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_tick #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bit_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 busy,
   output logic                 done
);

   localparam int              CNT_W       = $clog2(DATA_BITS) + 1;
   localparam logic [CNT_W-1:0] C_LAST_DATA = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] C_LAST_STOP = CNT_W'(STOP_BITS - 1);
   localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
   localparam logic            C_PAR_EN    = (PARITY_EN != 0);
   localparam logic            C_ODD       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   state_t               state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 parity_q;
   logic                 txd_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 accept_w;

   assign accept_w = tx_valid & ready_q;

   // cnt_q indexes data bits in DATA and is reused to count stop bits in STOP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         parity_q <= 1'b0;
         txd_q    <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept_w) begin
                  shift_q  <= tx_data;
                  parity_q <= (^tx_data) ^ C_ODD;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  if (bit_tick) begin
                     state_q <= S_START;
                     txd_q   <= 1'b0;
                  end else begin
                     state_q <= S_SYNC;
                  end
               end
            end
            S_SYNC: begin
               if (bit_tick) begin
                  state_q <= S_START;
                  txd_q   <= 1'b0;
               end
            end
            S_START: begin
               if (bit_tick) begin
                  state_q <= S_DATA;
                  txd_q   <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  cnt_q   <= '0;
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  if (cnt_q == C_LAST_DATA) begin
                     if (C_PAR_EN) begin
                        state_q <= S_PARITY;
                        txd_q   <= parity_q;
                     end else begin
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                        cnt_q   <= '0;
                     end
                  end else begin
                     txd_q   <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     cnt_q   <= cnt_q + C_ONE;
                  end
               end
            end
            S_PARITY: begin
               if (bit_tick) begin
                  state_q <= S_STOP;
                  txd_q   <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_STOP: begin
               if (bit_tick) begin
                  if (cnt_q == C_LAST_STOP) begin
                     state_q <= S_IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + C_ONE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               txd_q   <= 1'b1;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready = ready_q;
   assign txd      = txd_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

`default_nettype wire
